// File: rtl/otp_gen_ctrl.sv
// OTP generation controller: free-running 16-bit LFSR, rejection-sampled BCD digits,
// one-cycle delivery strobe and a lockout window armed by the reset_sys rising edge.
module otp_gen_ctrl #(
   parameter logic [15:0] LFSR_SEED      = 16'hACE1,
   parameter int unsigned LOCKOUT_CYCLES = 250_000_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        gen_req,
   input  logic        reset_sys,
   output logic [15:0] lfsr_digit,
   output logic        lfsr_latch,
   output logic        busy,
   output logic        locked,
   output logic [7:0]  otp_count
);

   localparam int unsigned   CW          = $clog2(LOCKOUT_CYCLES + 1);
   localparam logic [CW-1:0] LOCK_RELOAD = CW'(LOCKOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_COLLECT,
      S_PRESENT,
      S_DONE,
      S_LOCKOUT
   } state_e;

   state_e        state_q;
   logic [15:0]   lfsr_q, lfsr_d;
   logic [15:0]   word_q;
   logic [2:0]    idx_q;
   logic          rs_q, rse_q, rse_d;
   logic [CW-1:0] lock_cnt_q;
   logic [15:0]   digit_q;
   logic          latch_q, busy_q, locked_q;
   logic [7:0]    count_q;
   logic [3:0]    nib;

   always_comb begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      if (lfsr_q == '0) lfsr_d = LFSR_SEED;
      nib   = lfsr_q[3:0];
      rse_d = reset_sys & ~rs_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         lfsr_q     <= LFSR_SEED;
         word_q     <= '0;
         idx_q      <= '0;
         rs_q       <= 1'b0;
         rse_q      <= 1'b0;
         lock_cnt_q <= '0;
         digit_q    <= '0;
         latch_q    <= 1'b0;
         busy_q     <= 1'b0;
         locked_q   <= 1'b0;
         count_q    <= '0;
      end else begin
         lfsr_q  <= lfsr_d;
         rs_q    <= reset_sys;
         rse_q   <= rse_d;
         latch_q <= 1'b0;

         // The PRESENT strobe is committed even when a lockout edge lands in the same cycle.
         if (state_q == S_PRESENT) begin
            latch_q <= 1'b1;
            digit_q <= word_q;
            if (count_q != 8'hFF) count_q <= count_q + 8'd1;
         end

         if (rse_q) begin
            state_q    <= S_LOCKOUT;
            lock_cnt_q <= LOCK_RELOAD;
            locked_q   <= 1'b1;
            busy_q     <= 1'b0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (gen_req) begin
                     state_q <= S_COLLECT;
                     idx_q   <= '0;
                     busy_q  <= 1'b1;
                  end
               end
               S_COLLECT: begin
                  if (nib <= 4'd9) begin
                     case (idx_q[1:0])
                        2'd0:    word_q[15:12] <= nib;
                        2'd1:    word_q[11:8]  <= nib;
                        2'd2:    word_q[7:4]   <= nib;
                        default: word_q[3:0]   <= nib;
                     endcase
                     idx_q <= idx_q + 3'd1;
                     if (idx_q == 3'd3) state_q <= S_PRESENT;
                  end
               end
               S_PRESENT: begin
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
               end
               S_DONE: begin
                  if (!gen_req) state_q <= S_IDLE;
               end
               S_LOCKOUT: begin
                  if (lock_cnt_q == '0) begin
                     state_q  <= S_IDLE;
                     locked_q <= 1'b0;
                  end else begin
                     lock_cnt_q <= lock_cnt_q - CW'(1);
                  end
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign lfsr_digit = digit_q;
   assign lfsr_latch = latch_q;
   assign busy       = busy_q;
   assign locked     = locked_q;
   assign otp_count  = count_q;

endmodule

// File: doc/otp_gen_ctrl.md
# otp_gen_ctrl

OTP generation controller for the hardware-authentication datapath. It owns the 16-bit LFSR and turns its raw output into four decimal (BCD) digits by rejection sampling. It delivers the result to the authentication FSM on the `lfsr_digit` / `lfsr_latch` interface. It also enforces a lockout period after the FSM signals `reset_sys` (three wrong attempts), so a new OTP cannot be requested during lockout.

## Interface
- `LFSR_SEED`, default 16'hACE1: LFSR reset value. Must be non-zero.
- `LOCKOUT_CYCLES`, default 250_000_000: lockout length in clk cycles (5 s at 50 MHz). Must be at least 1.
- `clk`, input, 1: system clock, rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `gen_req`, input, 1: level request for a new OTP. Driven high while the FSM is in GENERATE_OTP.
- `reset_sys`, input, 1: lockout trigger from the FSM. Only its rising edge is used.
- `lfsr_digit`, output, 16: OTP as {d0,d1,d2,d3}. d0 is in [15:12] and each nibble is in 0..9.
- `lfsr_latch`, output, 1: one-cycle strobe. `lfsr_digit` is valid during the strobe and afterwards.
- `busy`, output, 1: high in COLLECT and PRESENT.
- `locked`, output, 1: high in LOCKOUT.
- `otp_count`, output, 8: number of OTPs delivered, saturating at 255.

## Operation
- **LFSR**
  - Free-running: it advances every cycle in every state, so user timing acts as an entropy source.
  - Update rule: next = {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
  - If the register is ever all-zero, it reloads `LFSR_SEED` on the next edge.
- **Reset values**
  - LFSR = `LFSR_SEED`; state = IDLE.
  - `lfsr_digit` = 0, `lfsr_latch` = 0, `busy` = 0, `locked` = 0, `otp_count` = 0.
  - Digit index = 0; `reset_sys` edge-detect register = 0.
- **States**
  - IDLE: if `gen_req`=1, go to COLLECT and clear the digit index.
  - COLLECT: each cycle, sample n = lfsr[3:0].
    - If n ≤ 9, store n at the digit index (0 is the MSB nibble) and increment the index.
    - If n ≥ 10, discard it and leave the index unchanged.
    - After the 4th accepted digit, go to PRESENT.
  - PRESENT (one cycle): `lfsr_latch`=1, `lfsr_digit` = the assembled word, `otp_count` += 1 (saturating). Then go to DONE.
  - DONE: wait for `gen_req`=0, then go to IDLE. This prevents a second OTP per request.
  - LOCKOUT: counter loads `LOCKOUT_CYCLES`-1 and decrements to 0. At 0 it goes to IDLE. `gen_req` is ignored.
- **`reset_sys` rising edge**
  - Detected as `reset_sys` & ~`reset_sys`_q.
  - Forces LOCKOUT from any state, with highest priority.
  - In COLLECT: the partial digits are discarded and no strobe is issued. `lfsr_digit` keeps its previous value.
  - During LOCKOUT: a new edge reloads the counter.
  - A level held high does not retrigger.
- **Output hold rules**
  - `lfsr_digit` changes only in PRESENT. It holds through LOCKOUT and IDLE.
  - `lfsr_latch` is never high in consecutive cycles.
- **Register widths**
  - Lockout counter: $clog2(`LOCKOUT_CYCLES`+1) bits.
  - Digit index: 3 bits.

## Timing
- **OTP latency**
  - `gen_req` sampled high in IDLE at edge N puts the block in COLLECT at N+1.
  - Best case: 4 accepts at edges N+1..N+4, then `lfsr_latch` is high in the cycle after edge N+5.
  - Each rejected nibble adds one cycle.
  - No upper bound is guaranteed. The expected extra delay is about 2.4 cycles.
- **Outputs**
  - `busy` is high from the cycle after request acceptance through the PRESENT cycle.
- **Lockout timing**
  - The `reset_sys` rising edge is registered, so `locked` rises 2 cycles after `reset_sys` rises.
  - `locked` stays high for exactly `LOCKOUT_CYCLES` cycles.
  - IDLE follows. A `gen_req` that is still high is accepted on the first IDLE cycle.
- **Simultaneous events**
  - A `reset_sys` edge in the same cycle as the 4th accept wins: LOCKOUT, no strobe.
  - A `reset_sys` edge during PRESENT: the strobe that is already registered completes, then LOCKOUT follows.
- **Asynchronous reset mid-operation**
  - All outputs clear immediately.
  - The LFSR returns to the seed.
  - Any strobe in progress is lost.

## Test plan
- **Reset:** assert `reset`=0 mid-COLLECT → all outputs are 0 in the same cycle and the LFSR equals 16'hACE1 after release.
- **Single OTP:** pulse `gen_req` high for 1 cycle → exactly one `lfsr_latch` pulse.
  - Every nibble of `lfsr_digit` ≤ 9.
  - The value matches the bit-accurate software LFSR/rejection model.
  - Latency ≥ 5 cycles; `otp_count`=1.
- **Held request:** hold `gen_req`=1 for 200 cycles → exactly one strobe; release, then raise again → a second strobe and `otp_count`=2.
- **Lockout:** with `LOCKOUT_CYCLES`=20, raise `reset_sys` and hold it for 50 cycles with `gen_req`=1 →
  - `locked` is high for exactly 20 cycles;
  - there is no strobe during lockout;
  - a strobe follows within 5 + (rejects) cycles after `locked` falls.
- **Abort:** issue a `reset_sys` edge 2 cycles into COLLECT → no strobe, `lfsr_digit` keeps its prior value, and `locked` goes high.
- **Rejection and saturation:** run 300 requests →
  - all 1200 nibbles are in 0..9;
  - each digit value 0..9 appears 90-150 times;
  - `otp_count` saturates at 255.
